// File: rtl/dsp_cas_ctrl_pkg.sv
// Shared constants and types for the DSP cascade controller.
package dsp_cas_ctrl_pkg;

  localparam int unsigned DSP_LAT     = 4;   // AREG/BREG=2, MREG=1, PREG=1
  localparam int unsigned DSP_A_W     = 30;
  localparam int unsigned DSP_D_W     = 27;
  localparam int unsigned DSP_B_W     = 18;
  localparam int unsigned DSP_P_W     = 48;
  localparam int unsigned DSP_PACK_SH = 18;  // default offset of the high weight in the pre-adder sum
  localparam int unsigned LEN_W       = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } cas_state_e;

endpackage

// File: rtl/dsp_cas_ctrl_skew.sv
// Depth-N register delay line used to skew DSP operands per cascade stage.
module dsp_skew_line #(
  parameter int unsigned W = 18,
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (N == 0) begin : g_pass
    assign dout = din;
  end else begin : g_pipe
    logic [W-1:0] pipe_q [N];

    // Shift the operand one slot per cycle; reset flushes the whole line.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < int'(N); k++) pipe_q[k] <= '0;
      end else begin
        pipe_q[0] <= din;
        for (int k = 1; k < int'(N); k++) pipe_q[k] <= pipe_q[k-1];
      end
    end

    assign dout = pipe_q[N-1];
  end

endmodule

// File: rtl/dsp_cas_ctrl.sv
// Frame controller for a cascaded packed-weight DSP chain: issues skewed
// operands, tags beats through the chain latency and accumulates the two
// packed results unpacked from the last stage's P output.
module dsp_cas_ctrl #(
  parameter int unsigned CAS_NUM = 4,
  parameter int unsigned FEAT_W  = 8,
  parameter int unsigned WGT_W   = 8,
  parameter int unsigned PACK_SH = dsp_cas_ctrl_pkg::DSP_PACK_SH,
  parameter int unsigned ACC_W   = 32
) (
  input  logic                       I_clk,
  input  logic                       I_rst,
  input  logic                       I_start,
  input  logic [15:0]                I_len,
  input  logic                       I_vld,
  output logic                       O_rdy,
  input  logic [CAS_NUM*FEAT_W-1:0]  I_feature,
  input  logic [CAS_NUM*WGT_W-1:0]   I_weight_l,
  input  logic [CAS_NUM*WGT_W-1:0]   I_weight_h,
  output logic [CAS_NUM*18-1:0]      O_dsp_feature,
  output logic [CAS_NUM*30-1:0]      O_dsp_weight_l,
  output logic [CAS_NUM*27-1:0]      O_dsp_weight_h,
  input  logic [47:0]                I_dsp_p,
  output logic signed [ACC_W-1:0]    O_res_l,
  output logic signed [ACC_W-1:0]    O_res_h,
  output logic                       O_done,
  output logic                       O_busy
);

  import dsp_cas_ctrl_pkg::*;

  localparam int unsigned LAT = DSP_LAT + CAS_NUM - 1;

  cas_state_e              state_q, state_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic                    rdy_q, rdy_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    acc_clr;
  logic                    xfer;
  logic                    tag;
  logic [LAT-1:0]          vld_sr_q;
  logic signed [ACC_W-1:0] acc_l_q, acc_h_q;
  logic signed [ACC_W-1:0] unp_l, unp_h;

  assign xfer = I_vld & rdy_q;
  assign tag  = vld_sr_q[LAT-1];

  // Next-state, beat counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_start) begin
          acc_clr = 1'b1;
          if (I_len != '0) begin
            cnt_d   = I_len;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (vld_sr_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rdy_d  = (state_d == S_RUN);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State register and registered control outputs.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Unpack P: the high field absorbs the borrow left by a negative low field.
  always_comb begin
    unp_l = ACC_W'($signed(I_dsp_p[PACK_SH-1:0]));
    unp_h = ACC_W'($signed(I_dsp_p[DSP_P_W-1:PACK_SH])) + ACC_W'(I_dsp_p[PACK_SH-1]);
  end

  // Beat tags follow the chain latency; tagged P values wrap into the accumulators.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      vld_sr_q <= '0;
      acc_l_q  <= '0;
      acc_h_q  <= '0;
    end else begin
      vld_sr_q <= {vld_sr_q[LAT-2:0], xfer};
      if (acc_clr) begin
        acc_l_q <= '0;
        acc_h_q <= '0;
      end else if (tag) begin
        acc_l_q <= acc_l_q + unp_l;
        acc_h_q <= acc_h_q + unp_h;
      end
    end
  end

  for (genvar i = 0; i < int'(CAS_NUM); i++) begin : g_stage
    logic [DSP_B_W-1:0] feat_c;
    logic [DSP_A_W-1:0] wl_c;
    logic [DSP_D_W-1:0] wh_c;

    // Bubbles feed zero operands so the chain keeps advancing cleanly.
    always_comb begin
      feat_c = '0;
      wl_c   = '0;
      wh_c   = '0;
      if (xfer) begin
        feat_c = DSP_B_W'($signed(I_feature[i*FEAT_W +: FEAT_W]));
        wl_c   = DSP_A_W'($signed(I_weight_l[i*WGT_W +: WGT_W]));
        wh_c   = DSP_D_W'($signed(I_weight_h[i*WGT_W +: WGT_W])) << PACK_SH;
      end
    end

    dsp_skew_line #(.W(DSP_B_W), .N(i + 1)) u_skew_b (
      .clk (I_clk), .rst (I_rst), .din (feat_c),
      .dout(O_dsp_feature[i*DSP_B_W +: DSP_B_W])
    );
    dsp_skew_line #(.W(DSP_A_W), .N(i + 1)) u_skew_a (
      .clk (I_clk), .rst (I_rst), .din (wl_c),
      .dout(O_dsp_weight_l[i*DSP_A_W +: DSP_A_W])
    );
    dsp_skew_line #(.W(DSP_D_W), .N(i + 1)) u_skew_d (
      .clk (I_clk), .rst (I_rst), .din (wh_c),
      .dout(O_dsp_weight_h[i*DSP_D_W +: DSP_D_W])
    );
  end

  assign O_rdy   = rdy_q;
  assign O_busy  = busy_q;
  assign O_done  = done_q;
  assign O_res_l = acc_l_q;
  assign O_res_h = acc_h_q;

endmodule

// File: tb/tb_dsp_cas_ctrl.sv
// Directed bench for dsp_cas_ctrl with a behavioural model of the DSP cascade.
module tb_dsp_cas_ctrl;

  localparam int CAS = 4;
  localparam int LAT = 4 + CAS - 1;

  logic               clk = 1'b0;
  logic               rst, start, vld, rdy, done, busy;
  logic [15:0]        len;
  logic [CAS*8-1:0]   feat, wl, wh;
  logic [CAS*18-1:0]  dsp_f;
  logic [CAS*30-1:0]  dsp_wl;
  logic [CAS*27-1:0]  dsp_wh;
  logic [47:0]        dsp_p;
  logic signed [31:0] res_l, res_h;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_xfer = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_cas_ctrl #(
    .CAS_NUM(CAS), .FEAT_W(8), .WGT_W(8), .PACK_SH(18), .ACC_W(32)
  ) dut (
    .I_clk         (clk),
    .I_rst         (rst),
    .I_start       (start),
    .I_len         (len),
    .I_vld         (vld),
    .O_rdy         (rdy),
    .I_feature     (feat),
    .I_weight_l    (wl),
    .I_weight_h    (wh),
    .O_dsp_feature (dsp_f),
    .O_dsp_weight_l(dsp_wl),
    .O_dsp_weight_h(dsp_wh),
    .I_dsp_p       (dsp_p),
    .O_res_l       (res_l),
    .O_res_h       (res_h),
    .O_done        (done),
    .O_busy        (busy)
  );

  // DSP chain model: stage i product surfaces on P LAT-1-i cycles after its operands.
  logic [47:0] p_pipe [LAT-1];

  function automatic logic [47:0] stage_prod(input int i);
    longint a, d, b;
    a = longint'($signed(dsp_wl[i*30 +: 30]));
    d = longint'($signed(dsp_wh[i*27 +: 27]));
    b = longint'($signed(dsp_f[i*18 +: 18]));
    return 48'((a + d) * b);
  endfunction

  always @(posedge clk) begin
    logic [47:0] nxt [LAT-1];
    for (int k = 0; k < LAT-1; k++) begin
      if (k < LAT-2) nxt[k] = p_pipe[k+1];
      else           nxt[k] = 48'd0;
    end
    for (int i = 0; i < CAS; i++) nxt[LAT-2-i] = nxt[LAT-2-i] + stage_prod(i);
    p_pipe <= nxt;
  end

  assign dsp_p = p_pipe[0];

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [7:0] f, input logic [7:0] w_l, input logic [7:0] w_h);
    feat = {CAS{f}};
    wl   = {CAS{w_l}};
    wh   = {CAS{w_h}};
  endtask

  task automatic start_frame(input logic [15:0] n);
    start = 1'b1;
    len   = n;
    step();
    start = 1'b0;
    len   = 16'd9;
  endtask

  task automatic send_beats(input int n_beats, input int gap, input bit poke_start, input string tag);
    int   sent = 0;
    int   gap_left = 0;
    int   n = 0;
    bit   first = 1'b1;
    bit   bubble_done = 1'b0;
    bit   poked = 1'b0;
    logic rdy_s;
    logic is_v;
    while (sent < n_beats && n < 100) begin
      is_v = (gap_left == 0);
      vld  = is_v;
      if (!is_v) gap_left--;
      if (poke_start && sent == 1 && !poked) begin
        start = 1'b1;
        len   = 16'd5;
        poked = 1'b1;
      end
      rdy_s = rdy;
      step();
      n++;
      start = 1'b0;
      if (is_v && rdy_s) begin
        sent++;
        last_xfer = cyc - 1;
        gap_left  = gap;
        if (first) begin
          chk({tag, "/op_feat0"}, longint'($signed(dsp_f[17:0])), longint'($signed(feat[7:0])));
          chk({tag, "/op_wh0"}, longint'($signed(dsp_wh[26:0])), longint'($signed(wh[7:0])) * 262144);
          first = 1'b0;
        end
      end else if (!is_v && !bubble_done) begin
        chk({tag, "/bubble_op"}, longint'(dsp_f[17:0]), 0);
        bubble_done = 1'b1;
      end
    end
    vld = 1'b0;
    chk({tag, "/beats_sent"}, sent, n_beats);
  endtask

  task automatic wait_done(input string tag, input longint exp_l, input longint exp_h);
    int n = 0;
    bit rdy_bad = 1'b0;
    while (!done && n < 40) begin
      if (rdy) rdy_bad = 1'b1;
      step();
      n++;
    end
    chk({tag, "/done"}, done, 1);
    chk({tag, "/rdy_outside_run"}, rdy_bad, 0);
    chk({tag, "/done_latency"}, cyc - last_xfer, LAT + 2);
    chk({tag, "/res_l"}, res_l, exp_l);
    chk({tag, "/res_h"}, res_h, exp_h);
    step();
    chk({tag, "/done_pulse"}, done, 0);
    chk({tag, "/busy_idle"}, busy, 0);
    chk({tag, "/hold_l"}, res_l, exp_l);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    vld   = 1'b0;
    len   = 16'd0;
    set_ops(8'd0, 8'd0, 8'd0);
    repeat (3) step();
    chk("rst/busy", busy, 0);
    chk("rst/rdy", rdy, 0);
    chk("rst/done", done, 0);
    chk("rst/res_l", res_l, 0);
    chk("rst/res_h", res_h, 0);
    rst = 1'b0;
    step();
    chk("idle/rdy", rdy, 0);

    // len=1, f=2, wl=3, wh=-1
    set_ops(8'd2, 8'd3, 8'hFF);
    start_frame(16'd1);
    chk("f1/rdy_run", rdy, 1);
    chk("f1/busy_run", busy, 1);
    send_beats(1, 0, 1'b0, "f1");
    wait_done("f1", 24, -8);

    // len=3 with two-cycle gaps, f=1, wl=-5, wh=7
    set_ops(8'd1, 8'hFB, 8'd7);
    start_frame(16'd3);
    send_beats(3, 2, 1'b0, "f2");
    wait_done("f2", -60, 84);

    // Zero-length frame completes immediately with cleared results
    start = 1'b1;
    len   = 16'd0;
    vld   = 1'b1;
    step();
    start = 1'b0;
    vld   = 1'b0;
    chk("z/done", done, 1);
    chk("z/rdy", rdy, 0);
    chk("z/res_l", res_l, 0);
    chk("z/res_h", res_h, 0);
    step();
    chk("z/done_pulse", done, 0);
    chk("z/rdy_after", rdy, 0);

    // Reset in the middle of DRAIN, then a clean frame
    set_ops(8'd3, 8'd5, 8'd7);
    start_frame(16'd2);
    send_beats(2, 0, 1'b0, "ab");
    step();
    step();
    chk("ab/rdy_drain", rdy, 0);
    chk("ab/busy_drain", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ab/busy_rst", busy, 0);
    chk("ab/ops_rst", |dsp_f, 0);
    chk("ab/res_rst", res_l, 0);
    set_ops(8'd1, 8'd1, 8'd1);
    start_frame(16'd1);
    send_beats(1, 0, 1'b0, "rs");
    wait_done("rs", 4, 4);

    // Start pulse during RUN must not restart the frame
    set_ops(8'd1, 8'd2, 8'd3);
    start_frame(16'd3);
    send_beats(3, 1, 1'b1, "ms");
    wait_done("ms", 24, 36);

    // Extreme operands exercise the borrow path
    set_ops(8'h80, 8'h80, 8'h7F);
    start_frame(16'd1);
    send_beats(1, 0, 1'b0, "ex");
    wait_done("ex", 65536, -65024);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
